fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 16-bit pipelined core: owns the PC, issues one read at a
//  time to instruction memory, and loads the IF/ID pipeline register consumed by decode.
//  Handles variable memory latency, decode stalls, branch redirects from EX, and HALT.
// PARAMETERS
//  WIDTH       16       PC / instruction width (fixed at 16 for this core)
//  RESET_PC    16'h0000 PC value after reset
//  NOP_INSTR   16'h0800 instruction driven on if_id_instr when if_id_valid=0
//  HALT_OPC    5'b00000 opcode (instr[15:11]) that stops fetch
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   synchronous reset, active-high
//  imem_rd        out  1   read request; held high until imem_done
//  imem_addr      out  16  read address (= PC while imem_rd=1)
//  imem_data      in   16  instruction, valid when imem_done=1
//  imem_done      in   1   read complete; only meaningful while imem_rd=1
//  stall_id       in   1   decode cannot accept a new instruction this cycle
//  redirect_valid in   1   one-cycle pulse from EX: branch/jump taken or mispredicted
//  redirect_pc    in   16  target PC, valid with redirect_valid
//  if_id_valid    out  1   IF/ID holds a real instruction
//  if_id_instr    out  16  fetched instruction (NOP_INSTR when invalid)
//  if_id_pc_inc   out  16  PC of that instruction + 2
//  halted         out  1   fetch stopped on HALT
// BEHAVIOUR
//  Reset: PC=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc_inc=0,
//   halted=0, imem_rd=0. Reset mid-request: outstanding response discarded; memory
//   side is reset together with the core.
//  States: FETCH, BUFFERED, DRAIN, HALTED (encodings in fetch_defs.vh).
//  FETCH: imem_rd=1, imem_addr=PC. done may arrive in the first cycle (zero-wait).
//   - done & !stall_id: IF/ID <= {1, imem_data, PC+2}; PC <= PC+2; go HALTED if
//     imem_data[15:11]==HALT_OPC, else stay FETCH and request next PC the following cycle.
//   - done & stall_id: data into 1-entry buffer (instr, PC+2); PC <= PC+2; go BUFFERED.
//   - not done: hold. IF/ID holds if stall_id, else if_id_valid <= 0 (bubble).
//  BUFFERED: imem_rd=0. When !stall_id: buffer -> IF/ID; HALT check applied as in FETCH.
//  HALTED: imem_rd=0, halted=1, IF/ID drains to invalid once !stall_id. Exits only on
//   redirect or rst.
//  Redirect (highest priority, any state, wins over stall_id and done in the same cycle):
//   if_id_valid <= 0; buffer cleared; halted <= 0; PC <= redirect_pc.
//   - request outstanding and done not in this cycle -> DRAIN; else -> FETCH.
//  DRAIN: imem_rd=1 at the old address until done; response discarded; then FETCH at new PC.
//   Second redirect in DRAIN: PC updated, stay DRAIN.
//  Arithmetic: PC+2 is modulo 2^16 (16'hFFFE+2 = 16'h0000); no fault. redirect_pc[0]
//   is forced to 0.
//  IF/ID never changes while stall_id=1 && if_id_valid=1, unless a redirect occurs.
//  Throughput: 1 instr/cycle with zero-wait memory; no combinational path from stall_id
//   or redirect_valid to imem_rd.
// STRUCTURE
//  fetch_defs.vh: state encodings, HALT_OPC, NOP_INSTR, RESET_PC constants.
//  Sub-module: PC storage is the existing pc register module (16 x dff, no enable);
//   hold is done by muxing PC back into inA; reset value is applied in the next-PC mux.
//  IF/ID register and 1-entry buffer are built from dff in this file; next-state logic
//   is one combinational block.
// TESTING
//  1 Zero-wait memory, program 0x0000..0x0006, no stalls -> imem_addr 0,2,4,6 on
//    consecutive cycles; if_id_pc_inc 2,4,6,8; if_id_valid stays 1.
//  2 3-cycle memory latency -> one request per 3 cycles; if_id_valid=0 bubbles between;
//    imem_addr is stable while imem_rd=1.
//  3 stall_id on the done cycle for 2 cycles -> BUFFERED; IF/ID unchanged; buffered
//    instruction appears the cycle after stall_id drops; no extra imem_rd.
//  4 redirect_valid with target 16'h0040 while a request is outstanding -> DRAIN; stale data
//    is dropped; next request is at 0x0040; if_id_valid=0 in between.
//  5 Fetch of 16'h0000 (HALT) at PC 0x0010 -> halted=1, imem_rd=0; a later redirect to
//    0x0020 -> halted=0 and fetch resumes at 0x0020.
//  6 rst during DRAIN, and PC at 16'hFFFE fetching -> rst: PC=0, outputs at reset values;
//    wrap case: next address 16'h0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding and default constants.
package fetch_stage_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 16;
    localparam logic [15:0] DEFAULT_RESET_PC  = 16'h0000;
    localparam logic [15:0] DEFAULT_NOP_INSTR = 16'h0800;
    localparam logic [4:0]  DEFAULT_HALT_OPC  = 5'b00000;

    typedef enum logic [1:0] {
        StFetch    = 2'd0,
        StBuffered = 2'd1,
        StDrain    = 2'd2,
        StHalted   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc.sv
// Program counter storage: plain register, no enable and no reset; the caller muxes hold/reset.
module fetch_stage_pc #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] ina,
    output logic [WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        pc <= ina;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single outstanding reads and loads IF/ID,
// with a one-entry buffer for decode stalls, redirect draining and HALT handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [WIDTH-1:0] NOP_INSTR = DEFAULT_NOP_INSTR,
    parameter logic [4:0]      HALT_OPC  = DEFAULT_HALT_OPC
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_rd,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             imem_done,
    input  logic             stall_id,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             if_id_valid,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_pc_inc,
    output logic             halted
);

    localparam logic [WIDTH-1:0] PcStep  = {{(WIDTH-2){1'b0}}, 2'b10};
    localparam logic [WIDTH-1:0] AlignMk = ~{{(WIDTH-1){1'b0}}, 1'b1};

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, pc_next, pc_plus2, target;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_inc_q, pc_inc_d;
    logic [WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic [WIDTH-1:0] buf_pc_inc_q, buf_pc_inc_d;
    logic [WIDTH-1:0] drain_addr_q, drain_addr_d;

    fetch_stage_pc #(
        .WIDTH(WIDTH)
    ) u_pc (
        .clk(clk),
        .ina(pc_d),
        .pc (pc_q)
    );

    assign pc_plus2 = pc_q + PcStep;
    assign target   = redirect_pc & AlignMk;
    assign pc_d     = rst ? RESET_PC : pc_next;

    // Outputs depend only on registered state, never on stall_id or redirect_valid.
    assign imem_rd      = !rst && (state_q == StFetch || state_q == StDrain);
    assign imem_addr    = (state_q == StDrain) ? drain_addr_q : pc_q;
    assign if_id_valid  = valid_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc_inc = pc_inc_q;
    assign halted       = (state_q == StHalted);

    always_comb begin
        state_d      = state_q;
        pc_next      = pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_inc_d     = pc_inc_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_inc_d = buf_pc_inc_q;
        drain_addr_d = drain_addr_q;

        if (redirect_valid) begin
            valid_d      = 1'b0;
            instr_d      = NOP_INSTR;
            buf_instr_d  = NOP_INSTR;
            buf_pc_inc_d = '0;
            pc_next      = target;
            if ((state_q == StFetch || state_q == StDrain) && !imem_done) begin
                state_d = StDrain;
                // A second redirect while draining keeps the original in-flight address.
                if (state_q == StFetch) drain_addr_d = pc_q;
            end else begin
                state_d = StFetch;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_done) begin
                        pc_next = pc_plus2;
                        if (!stall_id) begin
                            valid_d  = 1'b1;
                            instr_d  = imem_data;
                            pc_inc_d = pc_plus2;
                            if (imem_data[WIDTH-1 -: 5] == HALT_OPC) state_d = StHalted;
                        end else begin
                            buf_instr_d  = imem_data;
                            buf_pc_inc_d = pc_plus2;
                            state_d      = StBuffered;
                        end
                    end else if (!stall_id) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
                StBuffered: begin
                    if (!stall_id) begin
                        valid_d  = 1'b1;
                        instr_d  = buf_instr_q;
                        pc_inc_d = buf_pc_inc_q;
                        state_d  = (buf_instr_q[WIDTH-1 -: 5] == HALT_OPC) ? StHalted : StFetch;
                    end
                end
                StDrain: begin
                    if (imem_done) state_d = StFetch;
                end
                StHalted: begin
                    if (!stall_id) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFetch;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_inc_q     <= '0;
            buf_instr_q  <= NOP_INSTR;
            buf_pc_inc_q <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_inc_q     <= pc_inc_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_inc_q <= buf_pc_inc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural instruction memory of adjustable latency.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_done;
    logic        stall_id;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_inc;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model: latency in cycles (1 = zero-wait), optional HALT word at one address.
    int          lat = 1;
    int          cnt;
    logic        halt_en = 1'b0;
    logic [15:0] halt_addr = 16'h0000;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_rd       (imem_rd),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .imem_done     (imem_done),
        .stall_id      (stall_id),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc_inc  (if_id_pc_inc),
        .halted        (halted)
    );

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return {5'b00011, a[10:0]};
    endfunction

    assign imem_done = imem_rd && (cnt == lat - 1);
    assign imem_data = (halt_en && imem_addr == halt_addr) ? 16'h0000 : word_at(imem_addr);

    always_ff @(posedge clk) begin
        if (rst || !imem_rd || imem_done) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        stall_id = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        tick();
        tick();
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_instr", 32'(if_id_instr), 32'h0800);
        check("rst_pcinc", 32'(if_id_pc_inc), 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_rd", 32'(imem_rd), 32'd0);

        // 1: zero-wait streaming
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", 32'(imem_addr), 32'(2 * i));
            check("t1_rd", 32'(imem_rd), 32'd1);
            tick();
            check("t1_valid", 32'(if_id_valid), 32'd1);
            check("t1_pcinc", 32'(if_id_pc_inc), 32'(2 * i + 2));
            check("t1_instr", 32'(if_id_instr), 32'h1800 + 32'(2 * i));
        end

        // 2: three-cycle latency, requests at 0x08 and 0x0A
        lat = 3;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 2; k++) begin
                check("t2_addr", 32'(imem_addr), 32'(8 + 2 * r));
                check("t2_rd", 32'(imem_rd), 32'd1);
                tick();
                check("t2_bubble", 32'(if_id_valid), 32'd0);
            end
            check("t2_addr_hold", 32'(imem_addr), 32'(8 + 2 * r));
            tick();
            check("t2_valid", 32'(if_id_valid), 32'd1);
            check("t2_pcinc", 32'(if_id_pc_inc), 32'(10 + 2 * r));
            check("t2_instr", 32'(if_id_instr), 32'h1808 + 32'(2 * r));
        end

        // 3: stall on the done cycle for two cycles
        lat = 1;
        stall_id = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t3_rd", 32'(imem_rd), 32'd0);
            check("t3_valid", 32'(if_id_valid), 32'd1);
            check("t3_pcinc", 32'(if_id_pc_inc), 32'h0C);
            check("t3_instr", 32'(if_id_instr), 32'h180A);
        end
        stall_id = 1'b0;
        tick();
        check("t3_buf_valid", 32'(if_id_valid), 32'd1);
        check("t3_buf_pcinc", 32'(if_id_pc_inc), 32'h0E);
        check("t3_buf_instr", 32'(if_id_instr), 32'h180C);
        check("t3_next_addr", 32'(imem_addr), 32'h0E);

        // 4: redirect to 0x0040 with a request outstanding
        lat = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        check("t4_drain_rd", 32'(imem_rd), 32'd1);
        check("t4_drain_addr", 32'(imem_addr), 32'h0E);
        check("t4_drain_valid", 32'(if_id_valid), 32'd0);
        tick();
        check("t4_stale_dropped", 32'(if_id_valid), 32'd0);
        check("t4_new_addr", 32'(imem_addr), 32'h40);
        lat = 1;
        tick();
        check("t4_valid", 32'(if_id_valid), 32'd1);
        check("t4_pcinc", 32'(if_id_pc_inc), 32'h42);
        check("t4_instr", 32'(if_id_instr), 32'h1840);

        // 5: HALT at 0x0010, then redirect to 0x0021 (bit 0 dropped)
        halt_en = 1'b1;
        halt_addr = 16'h0010;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect_valid = 1'b0;
        check("t5_addr", 32'(imem_addr), 32'h10);
        check("t5_valid0", 32'(if_id_valid), 32'd0);
        tick();
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_rd", 32'(imem_rd), 32'd0);
        check("t5_halt_instr", 32'(if_id_instr), 32'h0000);
        check("t5_halt_valid", 32'(if_id_valid), 32'd1);
        tick();
        check("t5_drain_valid", 32'(if_id_valid), 32'd0);
        check("t5_drain_instr", 32'(if_id_instr), 32'h0800);
        tick();
        check("t5_still_halted", 32'(halted), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0021;
        tick();
        redirect_valid = 1'b0;
        check("t5_resume_halted", 32'(halted), 32'd0);
        check("t5_resume_rd", 32'(imem_rd), 32'd1);
        check("t5_resume_addr", 32'(imem_addr), 32'h20);
        tick();
        check("t5_resume_pcinc", 32'(if_id_pc_inc), 32'h22);
        check("t5_resume_instr", 32'(if_id_instr), 32'h1820);

        // 6a: reset while draining
        lat = 3;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0030;
        tick();
        redirect_valid = 1'b0;
        check("t6_drain_addr", 32'(imem_addr), 32'h22);
        rst = 1'b1;
        tick();
        check("t6_rst_valid", 32'(if_id_valid), 32'd0);
        check("t6_rst_instr", 32'(if_id_instr), 32'h0800);
        check("t6_rst_pcinc", 32'(if_id_pc_inc), 32'h0);
        check("t6_rst_halted", 32'(halted), 32'd0);
        check("t6_rst_rd", 32'(imem_rd), 32'd0);
        rst = 1'b0;
        #1;
        check("t6_post_rst_addr", 32'(imem_addr), 32'h0);
        check("t6_post_rst_rd", 32'(imem_rd), 32'd1);

        // 6b: PC wrap from 0xFFFE
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        check("t6_wrap_addr", 32'(imem_addr), 32'hFFFE);
        tick();
        check("t6_wrap_valid", 32'(if_id_valid), 32'd1);
        check("t6_wrap_instr", 32'(if_id_instr), 32'h1FFE);
        check("t6_wrap_pcinc", 32'(if_id_pc_inc), 32'h0000);
        check("t6_wrap_next", 32'(imem_addr), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
